// File: rtl/picorv32_mem_axi_responder.sv
// picorv32_mem_axi_responder
//
// AXI4-Lite slave that accepts single-beat 32-bit reads and writes and
// replays each one as a request on a PicoRV32-style native memory port.
// One native transaction is outstanding at a time. Each AXI request channel
// has a one-deep holding register, so the next AW/W/AR can be accepted while
// the current native request or its response is still pending.
//
// Handshake semantics (all AXI channels): a transfer happens on the rising
// clk edge where VALID and READY are both 1. A source holds VALID and its
// payload stable until that edge. Here every READY is driven from flops
// only, and bvalid/rvalid with their payloads stay stable until accepted.
//
// Ports
//   clk, resetn          clock; asynchronous active-low reset
//   mem_axi_aw*          write address (awprot is ignored)
//   mem_axi_w*           write data and byte strobes
//   mem_axi_b*           write response (OKAY or SLVERR on timeout)
//   mem_axi_ar*          read address; arprot[2] marks an instruction fetch
//   mem_axi_r*           read data and response
//   mem_valid/instr/addr/wdata/wstrb   registered native request
//   mem_ready, mem_rdata                native completion
//   dbg_state_o          current FSM state, for observation only
//
// TIMEOUT_CYCLES: cycles mem_valid may stay high without mem_ready before the
// request is aborted with SLVERR. 0 disables the timeout. Range 0..65535.

module picorv32_mem_axi_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  output logic [1:0]  mem_axi_bresp,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic [1:0]  mem_axi_rresp,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WREQ  = 3'd1,
    S_WRESP = 3'd2,
    S_RREQ  = 3'd3,
    S_RRESP = 3'd4
  } state_e;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam bit          TMO_EN      = (TIMEOUT_CYCLES != 0);
  // The counter holds the number of cycles already spent waiting, so the
  // abort fires on the edge that would complete the TIMEOUT_CYCLES-th cycle.
  localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);

  // awprot and the low arprot bits carry no meaning on the native port.
  logic unused_prot;
  assign unused_prot = ^{mem_axi_awprot, mem_axi_arprot[1:0]};

  // Holding registers
  logic        aw_held_q, w_held_q, ar_held_q;
  logic [31:0] aw_addr_q, w_data_q, ar_addr_q;
  logic [3:0]  w_strb_q;
  logic        ar_instr_q;
  logic        grant_w, grant_r;

  // FSM and native/response registers
  state_e      state_q, state_d;
  logic        last_was_write_q, last_was_write_d;
  logic        mem_valid_q, mem_valid_d;
  logic        mem_instr_q, mem_instr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        wr_rdy, rd_rdy, tmo_hit;

  // A register never fills and clears on the same edge: it can only be
  // granted while full, and it can only fill while empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      ar_held_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      ar_addr_q  <= '0;
      ar_instr_q <= 1'b0;
    end else begin
      if (grant_w) begin
        aw_held_q <= 1'b0;
      end else if (mem_axi_awvalid && !aw_held_q) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= mem_axi_awaddr;
      end
      if (grant_w) begin
        w_held_q <= 1'b0;
      end else if (mem_axi_wvalid && !w_held_q) begin
        w_held_q <= 1'b1;
        w_data_q <= mem_axi_wdata;
        w_strb_q <= mem_axi_wstrb;
      end
      if (grant_r) begin
        ar_held_q <= 1'b0;
      end else if (mem_axi_arvalid && !ar_held_q) begin
        ar_held_q  <= 1'b1;
        ar_addr_q  <= mem_axi_araddr;
        ar_instr_q <= mem_axi_arprot[2];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= S_IDLE;
      last_was_write_q <= 1'b0;
      mem_valid_q      <= 1'b0;
      mem_instr_q      <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      mem_wstrb_q      <= '0;
      rdata_q          <= '0;
      bresp_q          <= RESP_OKAY;
      rresp_q          <= RESP_OKAY;
      tmo_cnt_q        <= '0;
    end else begin
      state_q          <= state_d;
      last_was_write_q <= last_was_write_d;
      mem_valid_q      <= mem_valid_d;
      mem_instr_q      <= mem_instr_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      mem_wstrb_q      <= mem_wstrb_d;
      rdata_q          <= rdata_d;
      bresp_q          <= bresp_d;
      rresp_q          <= rresp_d;
      tmo_cnt_q        <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    last_was_write_d = last_was_write_q;
    mem_valid_d      = mem_valid_q;
    mem_instr_d      = mem_instr_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    mem_wstrb_d      = mem_wstrb_q;
    rdata_d          = rdata_q;
    bresp_d          = bresp_q;
    rresp_d          = rresp_q;
    tmo_cnt_d        = tmo_cnt_q;
    grant_w          = 1'b0;
    grant_r          = 1'b0;
    wr_rdy           = aw_held_q && w_held_q;
    rd_rdy           = ar_held_q;
    tmo_hit          = TMO_EN && (tmo_cnt_q == TMO_LAST);

    case (state_q)
      S_IDLE: begin
        // Round-robin on a tie: take the type that was not granted last.
        if (wr_rdy && (!rd_rdy || !last_was_write_q)) begin
          grant_w = 1'b1;
        end else if (rd_rdy) begin
          grant_r = 1'b1;
        end
        if (grant_w) begin
          last_was_write_d = 1'b1;
          mem_addr_d       = aw_addr_q;
          mem_wdata_d      = w_data_q;
          mem_wstrb_d      = w_strb_q;
          mem_instr_d      = 1'b0;
          tmo_cnt_d        = '0;
          if (w_strb_q == 4'b0000) begin
            // PicoRV32 decodes wstrb==0 as a read, so never issue it.
            bresp_d = RESP_OKAY;
            state_d = S_WRESP;
          end else begin
            mem_valid_d = 1'b1;
            state_d     = S_WREQ;
          end
        end else if (grant_r) begin
          last_was_write_d = 1'b0;
          mem_addr_d       = ar_addr_q;
          mem_wstrb_d      = 4'b0000;
          mem_instr_d      = ar_instr_q;
          mem_valid_d      = 1'b1;
          tmo_cnt_d        = '0;
          state_d          = S_RREQ;
        end
      end
      S_WREQ, S_RREQ: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          if (state_q == S_WREQ) begin
            bresp_d = RESP_OKAY;
            state_d = S_WRESP;
          end else begin
            rdata_d = mem_rdata;
            rresp_d = RESP_OKAY;
            state_d = S_RRESP;
          end
        end else if (tmo_hit) begin
          mem_valid_d = 1'b0;
          if (state_q == S_WREQ) begin
            bresp_d = RESP_SLVERR;
            state_d = S_WRESP;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
            state_d = S_RRESP;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      S_WRESP: begin
        if (mem_axi_bready) state_d = S_IDLE;
      end
      S_RRESP: begin
        if (mem_axi_rready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_axi_awready = !aw_held_q;
  assign mem_axi_wready  = !w_held_q;
  assign mem_axi_arready = !ar_held_q;
  assign mem_axi_bvalid  = (state_q == S_WRESP);
  assign mem_axi_bresp   = bresp_q;
  assign mem_axi_rvalid  = (state_q == S_RRESP);
  assign mem_axi_rdata   = rdata_q;
  assign mem_axi_rresp   = rresp_q;
  assign mem_valid       = mem_valid_q;
  assign mem_instr       = mem_instr_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_wstrb       = mem_wstrb_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_picorv32_mem_axi_responder.sv
// Testbench for picorv32_mem_axi_responder: directed scenarios followed by
// randomized single transactions, checked against a word-array memory model
// and a queue of expected native requests.

module tb_picorv32_mem_axi_responder;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  picorv32_mem_axi_responder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready),
    .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
    .mem_axi_wvalid(wvalid), .mem_axi_wready(wready),
    .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid), .mem_axi_bready(bready), .mem_axi_bresp(bresp),
    .mem_axi_arvalid(arvalid), .mem_axi_arready(arready),
    .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
    .mem_axi_rvalid(rvalid), .mem_axi_rready(rready),
    .mem_axi_rdata(rdata), .mem_axi_rresp(rresp),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  // Expected native requests in grant order: {instr, wstrb, addr, wdata}
  logic [68:0] exp_q[$];
  logic [31:0] ref_mem[64];
  logic [31:0] dev_mem[64];
  logic        hang      = 1'b0;
  logic        stray_en  = 1'b0;
  int          mem_wait  = 0;
  int          req_count = 0;
  int          last_vcyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // ---------------- native memory device ----------------
  initial begin
    logic        in_req;
    int          vc, wc;
    logic [31:0] a_cap;
    logic [68:0] e;
    in_req = 1'b0; vc = 0; wc = 0; a_cap = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (!resetn) begin
        in_req = 1'b0;
      end else if (mem_valid) begin
        if (!in_req) begin
          in_req = 1'b1; vc = 0; wc = 0; a_cap = mem_addr;
          req_count++;
          if (exp_q.size() == 0) begin
            chk("nat_unexpected_req", 32'(exp_q.size()), 1);
          end else begin
            e = exp_q.pop_front();
            chk("nat_addr", mem_addr, e[63:32]);
            chk("nat_wstrb", 32'(mem_wstrb), 32'(e[67:64]));
            chk("nat_instr", 32'(mem_instr), 32'(e[68]));
            if (e[67:64] != 4'b0) chk("nat_wdata", mem_wdata, e[31:0]);
          end
        end else begin
          chk("nat_addr_stable", mem_addr, a_cap);
        end
        vc++;
        if (!hang && wc == mem_wait) begin
          mem_ready = 1'b1;
          if (mem_wstrb == 4'b0) mem_rdata = dev_mem[mem_addr[7:2]];
          else dev_mem[mem_addr[7:2]] = merge(dev_mem[mem_addr[7:2]], mem_wdata, mem_wstrb);
          in_req = 1'b0;
          last_vcyc = vc;
        end else begin
          wc++;
        end
      end else begin
        if (in_req) begin
          in_req = 1'b0;
          last_vcyc = vc;
        end
        if (stray_en) mem_ready = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    resetn = 1'b0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0; awprot = '0; arprot = '0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_aw(input logic [31:0] a, input int dly);
    int n;
    n = 0;
    repeat (dly + 1) @(negedge clk);
    awvalid = 1'b1; awaddr = a; awprot = 3'($urandom_range(0, 7));
    while (!awready && n < 200) begin @(negedge clk); n++; end
    chk("aw_handshake", 32'(n < 200), 1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int n;
    n = 0;
    repeat (dly + 1) @(negedge clk);
    wvalid = 1'b1; wdata = d; wstrb = s;
    while (!wready && n < 200) begin @(negedge clk); n++; end
    chk("w_handshake", 32'(n < 200), 1);
    @(negedge clk);
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [2:0] p, input int dly);
    int n;
    n = 0;
    repeat (dly + 1) @(negedge clk);
    arvalid = 1'b1; araddr = a; arprot = p;
    while (!arready && n < 200) begin @(negedge clk); n++; end
    chk("ar_handshake", 32'(n < 200), 1);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic recv_b(input int hold, output logic [1:0] resp);
    int n;
    logic [1:0] r0;
    n = 0;
    while (!bvalid && n < 300) begin @(negedge clk); n++; end
    chk("b_wait", 32'(n < 300), 1);
    r0 = bresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("b_hold_valid", 32'(bvalid), 1);
      chk("b_hold_resp", 32'(bresp), 32'(r0));
    end
    resp = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("b_drop", 32'(bvalid), 0);
  endtask

  task automatic recv_r(input int hold, output logic [31:0] data, output logic [1:0] resp);
    int n;
    logic [31:0] d0;
    n = 0;
    while (!rvalid && n < 300) begin @(negedge clk); n++; end
    chk("r_wait", 32'(n < 300), 1);
    d0 = rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("r_hold_valid", 32'(rvalid), 1);
      chk("r_hold_data", rdata, d0);
    end
    data = rdata;
    resp = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("r_drop", 32'(rvalid), 0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int daw, input int dw, input int hold);
    logic [1:0] r;
    int rc;
    rc = req_count;
    if (s != 4'b0) exp_q.push_back({1'b0, s, a, d});
    ref_mem[a[7:2]] = merge(ref_mem[a[7:2]], d, s);
    fork
      send_aw(a, daw);
      send_w(d, s, dw);
      recv_b(hold, r);
    join
    chk("wr_bresp", 32'(r), 0);
    chk("wr_native_count", 32'(req_count - rc), (s != 4'b0) ? 1 : 0);
    if (s != 4'b0) chk("wr_cycles", 32'(last_vcyc), 32'(mem_wait + 1));
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] p, input int dly, input int hold);
    logic [31:0] d;
    logic [1:0] r;
    exp_q.push_back({p[2], 4'b0000, a, 32'h0});
    fork
      send_ar(a, p, dly);
      recv_r(hold, d, r);
    join
    chk("rd_data", d, ref_mem[a[7:2]]);
    chk("rd_rresp", 32'(r), 0);
    chk("rd_cycles", 32'(last_vcyc), 32'(mem_wait + 1));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0]  r2;
    logic [31:0] d32, a32;
    logic [3:0]  s4;
    int          rc, seen;
    for (int i = 0; i < 64; i++) begin
      dev_mem[i] = $urandom | 32'h1;
      ref_mem[i] = dev_mem[i];
    end
    do_reset();

    // Reset values
    chk("rst_awready", 32'(awready), 1);
    chk("rst_wready", 32'(wready), 1);
    chk("rst_arready", 32'(arready), 1);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_mem_valid", 32'(mem_valid), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 0);
    chk("rst_mem_instr", 32'(mem_instr), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", 32'(bresp), 0);
    chk("rst_rresp", 32'(rresp), 0);

    // Single write, exact latency, memory ready in the first cycle
    mem_wait = 0;
    exp_q.push_back({1'b0, 4'hF, 32'h1000_0040, 32'hDEAD_BEEF});
    ref_mem[6'h10] = 32'hDEAD_BEEF;
    awvalid = 1; awaddr = 32'h1000_0040; awprot = 3'b000;
    wvalid = 1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    @(negedge clk);                     // edge N: AW and W handshake
    awvalid = 0; wvalid = 0;
    chk("w1_mem_valid_n", 32'(mem_valid), 0);
    chk("w1_awready_n", 32'(awready), 0);
    chk("w1_wready_n", 32'(wready), 0);
    @(negedge clk);                     // edge N+1
    chk("w1_mem_valid_n1", 32'(mem_valid), 1);
    chk("w1_mem_addr", mem_addr, 32'h1000_0040);
    chk("w1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("w1_mem_wstrb", 32'(mem_wstrb), 32'hF);
    chk("w1_bvalid_n1", 32'(bvalid), 0);
    @(negedge clk);                     // edge N+2
    chk("w1_bvalid_n2", 32'(bvalid), 1);
    chk("w1_bresp", 32'(bresp), 0);
    chk("w1_mem_valid_n2", 32'(mem_valid), 0);
    bready = 1;
    @(negedge clk);
    bready = 0;

    // Instruction fetch read with three wait cycles
    mem_wait = 3;
    dev_mem[0] = 32'h1234_5678;
    ref_mem[0] = 32'h1234_5678;
    do_read(32'h0000_0100, 3'b100, 0, 0);
    chk("fetch_valid_cycles", 32'(last_vcyc), 4);

    // W arrives well before AW
    mem_wait = 1;
    exp_q.push_back({1'b0, 4'b0011, 32'h2000_0008, 32'hCAFE_F00D});
    ref_mem[2] = merge(ref_mem[2], 32'hCAFE_F00D, 4'b0011);
    rc = req_count;
    send_w(32'hCAFE_F00D, 4'b0011, 0);
    chk("skew_wready_low", 32'(wready), 0);
    repeat (4) @(negedge clk);
    chk("skew_no_req_yet", 32'(req_count - rc), 0);
    chk("skew_wready_still_low", 32'(wready), 0);
    fork
      send_aw(32'h2000_0008, 0);
      recv_b(0, r2);
    join
    chk("skew_bresp", 32'(r2), 0);
    chk("skew_one_req", 32'(req_count - rc), 1);
    chk("skew_wready_back", 32'(wready), 1);

    // Zero-strobe write: OKAY without any native request
    do_write(32'h2000_000C, 32'h5555_AAAA, 4'b0000, 0, 0, 1);

    // Contention: W,R,W,R grant order from a fresh reset, 3-cycle back-pressure
    do_reset();
    mem_wait = 1;
    exp_q.push_back({1'b0, 4'hF, 32'h2000_0010, 32'h1111_1111});
    exp_q.push_back({1'b0, 4'h0, 32'h2000_0020, 32'h0});
    exp_q.push_back({1'b0, 4'hF, 32'h2000_0014, 32'h2222_2222});
    exp_q.push_back({1'b1, 4'h0, 32'h2000_0024, 32'h0});
    ref_mem[4] = 32'h1111_1111;
    ref_mem[5] = 32'h2222_2222;
    fork
      begin send_aw(32'h2000_0010, 0); send_aw(32'h2000_0014, 0); end
      begin send_w(32'h1111_1111, 4'hF, 0); send_w(32'h2222_2222, 4'hF, 0); end
      begin send_ar(32'h2000_0020, 3'b000, 0); send_ar(32'h2000_0024, 3'b100, 0); end
      begin
        logic [1:0] rb;
        recv_b(3, rb); chk("cont_b1", 32'(rb), 0);
        recv_b(3, rb); chk("cont_b2", 32'(rb), 0);
      end
      begin
        logic [31:0] rd;
        logic [1:0]  rr;
        recv_r(3, rd, rr); chk("cont_r1_data", rd, ref_mem[8]); chk("cont_r1_resp", 32'(rr), 0);
        recv_r(3, rd, rr); chk("cont_r2_data", rd, ref_mem[9]); chk("cont_r2_resp", 32'(rr), 0);
      end
    join
    chk("cont_all_granted", 32'(exp_q.size()), 0);

    // Timeout aborts: memory never answers
    hang = 1'b1;
    exp_q.push_back({1'b0, 4'h0, 32'h2000_0030, 32'h0});
    fork
      send_ar(32'h2000_0030, 3'b000, 0);
      recv_r(0, d32, r2);
    join
    chk("tmo_rd_rresp", 32'(r2), 32'h2);
    chk("tmo_rd_rdata", d32, 0);
    chk("tmo_rd_cycles", 32'(last_vcyc), TMO);
    exp_q.push_back({1'b0, 4'hF, 32'h2000_0034, 32'h7777_7777});
    fork
      send_aw(32'h2000_0034, 0);
      send_w(32'h7777_7777, 4'hF, 1);
      recv_b(0, r2);
    join
    chk("tmo_wr_bresp", 32'(r2), 32'h2);
    chk("tmo_wr_cycles", 32'(last_vcyc), TMO);

    // Asynchronous reset in the middle of a native write
    exp_q.push_back({1'b0, 4'hF, 32'h2000_0038, 32'h9999_9999});
    fork
      send_aw(32'h2000_0038, 0);
      send_w(32'h9999_9999, 4'hF, 0);
    join
    seen = 0;
    while (!mem_valid && seen < 20) begin @(negedge clk); seen++; end
    chk("rstmid_mem_valid_up", 32'(mem_valid), 1);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("rstmid_mem_valid_async", 32'(mem_valid), 0);
    hang = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rstmid_awready", 32'(awready), 1);
    chk("rstmid_wready", 32'(wready), 1);
    chk("rstmid_arready", 32'(arready), 1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bvalid || mem_valid) seen++;
    end
    chk("rstmid_no_stale", 32'(seen), 0);

    // Randomized single transactions against the memory model
    stray_en = 1'b1;
    for (int it = 0; it < 40; it++) begin
      a32 = 32'h2000_0000 | (32'($urandom_range(0, 63)) << 2);
      mem_wait = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1) begin
        s4  = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        d32 = $urandom;
        do_write(a32, d32, s4, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        do_read(a32, 3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end
    stray_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
